alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Issue/writeback sequencer that sits directly upstream of the registered RV32I integer ALU.
- Accepts one decoded-register-read instruction at a time: instruction word plus rs1/rs2 values.
- Decodes OP-IMM (0010011) and OP (0110011) into the 4-bit ALU op code and selects operands, then drives the ALU.
- Waits out the ALU's one-cycle registered latency, captures the result and presents it to writeback on a valid/ready handshake.

Parameters:
- DATA_WIDTH, 32, operand/result width; only 32 is supported because shift amount is operand B bits [4:0].
- OP_WIDTH, 4, ALU op code width.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream has an instruction.
- in_ready  output  1  block can accept an instruction.
- in_instr  input  32  RV32I instruction word.
- in_rs1_val  input  DATA_WIDTH  rs1 register value.
- in_rs2_val  input  DATA_WIDTH  rs2 register value.
- alu_op  output  OP_WIDTH  op code to the ALU.
- alu_a  output  DATA_WIDTH  ALU operand A.
- alu_b  output  DATA_WIDTH  ALU operand B.
- alu_out  input  DATA_WIDTH  ALU registered result.
- alu_fault  input  1  ALU invalid-op flag.
- res_valid  output  1  result available.
- res_ready  input  1  writeback accepts the result.
- res_data  output  DATA_WIDTH  result value.
- res_rd  output  5  destination register index.
- res_fault  output  1  illegal instruction or ALU fault.
- res_we  output  1  register write enable: rd != 0 and !res_fault.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - res_valid=0, res_fault=0, res_we=0.
  - res_data, res_rd, alu_op, alu_a, alu_b all zero.
  - in_ready=1 after release.
- State machine IDLE -> ISSUE -> CAPTURE -> DONE -> IDLE. in_ready=1 only in IDLE. No overlap between instructions.
- IDLE:
  - A transfer occurs on in_valid && in_ready at the clock edge.
  - On transfer, register rd=instr[11:7] and the decode result.
  - Legal: load alu_op/alu_a/alu_b and go to ISSUE.
  - Illegal: go to DONE with res_fault=1, res_data=0, res_we=0. The ALU is not issued.
- Decode:
  - opcode=instr[6:0], f3=instr[14:12], f7=instr[31:25].
  - alu_a=rs1 always.
  - OP-IMM: alu_b=sign-extended instr[31:20].
    - f3 000/010/011/100/110/111: op={0,f3}.
    - f3 001: legal only with f7=0000000, op 0001.
    - f3 101: f7=0000000 gives SRL 0101; f7=0100000 gives SRA 1101; else illegal.
  - OP: alu_b=rs2.
    - f7=0000000: op={0,f3}.
    - f7=0100000 with f3 000: SUB 1000.
    - f7=0100000 with f3 101: SRA 1101.
    - All other f7/f3 combinations are illegal, including f7=0000001 (M extension).
  - Any other opcode is illegal.
- ISSUE:
  - alu_op/alu_a/alu_b held stable; the ALU samples them at this edge.
  - Unconditionally go to CAPTURE.
- CAPTURE:
  - alu_out/alu_fault are valid during this cycle.
  - At the edge: res_data<=alu_out, res_fault<=alu_fault, res_we<=(rd!=0)&&!alu_fault.
  - Go to DONE.
- DONE:
  - res_valid=1; all res_* held stable until res_ready.
  - On res_ready go to IDLE and drop res_valid the next cycle.
- Latency:
  - Legal instruction: res_valid rises 3 cycles after the accepting edge.
  - Illegal instruction: res_valid rises 1 cycle after the accepting edge.
  - Minimum issue interval: 4 cycles legal, 2 cycles illegal, with res_ready held high.
- alu_* outputs keep their last issued values outside ISSUE. The ALU output is ignored outside CAPTURE.
- in_instr and in_rs*_val are sampled only at the transfer edge; later changes have no effect.
- Reset asserted in any state abandons the in-flight instruction; no result is ever emitted for it.

Test Plan:
- ADDI x5,x1,-1: instr 0xFFF08293, rs1=5 -> alu_op 0000, alu_b 0xFFFFFFFF. res_data=4, res_rd=5, res_we=1, res_fault=0; res_valid high 3 cycles after accept.
- SUB x3,x1,x2: instr 0x402081B3, rs1=10, rs2=3 -> alu_op 1000, res_data=7, res_rd=3, res_we=1.
- SRAI x4,x1,4: instr 0x4040D213, rs1=0x80000000 -> alu_op 1101, alu_b[4:0]=4, res_data=0xF8000000.
- Illegal instructions, each with res_valid 1 cycle after accept, res_fault=1, res_we=0, alu_* unchanged:
  - LW 0x0000A103.
  - MUL 0x022081B3.
- Backpressure and rd=0:
  - ADD x0,x1,x2 with res_ready low 5 cycles -> res_* stable and in_ready=0 throughout, res_we=0.
  - On res_ready=1, the next cycle is IDLE with in_ready=1, and a back-to-back instruction is accepted.
- Reset mid-op: assert rst_n=0 during ISSUE -> res_valid=0 and outputs zero immediately. After release in_ready=1 and no stale result appears.

Source files
------------

// File: rtl/alu_issue.sv
// Issue/writeback sequencer in front of the registered RV32I integer ALU.
// Decodes OP/OP-IMM, drives the ALU, waits out its latency and hands the result to writeback.
//
// state   | meaning
// IDLE    | ready for a new instruction
// ISSUE   | ALU operands stable, ALU samples them at the end of this cycle
// CAPTURE | ALU result valid, captured at the end of this cycle
// DONE    | result presented to writeback, held until res_ready
module alu_issue #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [DATA_WIDTH-1:0] in_rs1_val,
    input  logic [DATA_WIDTH-1:0] in_rs2_val,
    output logic [OP_WIDTH-1:0]   alu_op,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic                  alu_fault,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic [4:0]            res_rd,
    output logic                  res_fault,
    output logic                  res_we
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    state_t                state_q, state_d;
    logic [OP_WIDTH-1:0]   alu_op_q, alu_op_d;
    logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
    logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
    logic [4:0]            rd_q, rd_d;
    logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
    logic                  res_fault_q, res_fault_d;
    logic                  res_we_q, res_we_d;

    logic [6:0]            opcode;
    logic [2:0]            f3;
    logic [6:0]            f7;
    logic                  dec_legal;
    logic [OP_WIDTH-1:0]   dec_op;
    logic [DATA_WIDTH-1:0] dec_b;
    logic                  unused_rs1_idx;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];

    // Register indices are resolved upstream; only the values arrive here.
    assign unused_rs1_idx = ^in_instr[19:15];

    always_comb begin
        dec_legal = 1'b0;
        dec_op    = '0;
        dec_b     = in_rs2_val;
        case (opcode)
            OPC_OP_IMM: begin
                dec_b = {{(DATA_WIDTH-12){in_instr[31]}}, in_instr[31:20]};
                case (f3)
                    3'b001: begin
                        dec_legal = (f7 == F7_ZERO);
                        dec_op    = 4'b0001;
                    end
                    3'b101: begin
                        if (f7 == F7_ZERO) begin
                            dec_legal = 1'b1;
                            dec_op    = 4'b0101;
                        end else if (f7 == F7_ALT) begin
                            dec_legal = 1'b1;
                            dec_op    = 4'b1101;
                        end
                    end
                    default: begin
                        dec_legal = 1'b1;
                        dec_op    = {1'b0, f3};
                    end
                endcase
            end
            OPC_OP: begin
                if (f7 == F7_ZERO) begin
                    dec_legal = 1'b1;
                    dec_op    = {1'b0, f3};
                end else if (f7 == F7_ALT && f3 == 3'b000) begin
                    dec_legal = 1'b1;
                    dec_op    = 4'b1000;
                end else if (f7 == F7_ALT && f3 == 3'b101) begin
                    dec_legal = 1'b1;
                    dec_op    = 4'b1101;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        rd_d        = rd_q;
        res_data_d  = res_data_q;
        res_fault_d = res_fault_q;
        res_we_d    = res_we_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    rd_d = in_instr[11:7];
                    if (dec_legal) begin
                        alu_op_d = dec_op;
                        alu_a_d  = in_rs1_val;
                        alu_b_d  = dec_b;
                        state_d  = ISSUE;
                    end else begin
                        // Illegal: bypass the ALU and report straight away.
                        res_data_d  = '0;
                        res_fault_d = 1'b1;
                        res_we_d    = 1'b0;
                        state_d     = DONE;
                    end
                end
            end
            ISSUE: state_d = CAPTURE;
            CAPTURE: begin
                res_data_d  = alu_out;
                res_fault_d = alu_fault;
                res_we_d    = (rd_q != 5'd0) && !alu_fault;
                state_d     = DONE;
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            rd_q        <= '0;
            res_data_q  <= '0;
            res_fault_q <= 1'b0;
            res_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            rd_q        <= rd_d;
            res_data_q  <= res_data_d;
            res_fault_q <= res_fault_d;
            res_we_q    <= res_we_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign res_valid = (state_q == DONE);
    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign res_data  = res_data_q;
    assign res_rd    = rd_q;
    assign res_fault = res_fault_q;
    assign res_we    = res_we_q;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: a behavioural ALU stands in for the real one and
// expected writeback results come from instruction semantics.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr, in_rs1_val, in_rs2_val;
    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b;
    logic [31:0] alu_out = '0;
    logic        alu_fault = 1'b0;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [4:0]  res_rd;
    logic        res_fault, res_we;

    alu_issue dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_fault(alu_fault),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_rd(res_rd), .res_fault(res_fault), .res_we(res_we)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        fault;
        logic        we;
        int          lat;
        longint      acc;
    } exp_t;

    exp_t   sb[$];
    int     n_cmp = 0;
    int     n_err = 0;
    longint cyc = 0;
    bit     inj_fault = 1'b0;
    int     rr_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural registered ALU
    function automatic logic [31:0] alu_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a << b[4:0];
            4'd2:  return {31'b0, $signed(a) < $signed(b)};
            4'd3:  return {31'b0, a < b};
            4'd4:  return a ^ b;
            4'd5:  return a >> b[4:0];
            4'd6:  return a | b;
            4'd7:  return a & b;
            4'd8:  return a - b;
            4'd13: return 32'($signed(a) >>> b[4:0]);
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        alu_out   <= alu_calc(alu_op, alu_a, alu_b);
        alu_fault <= !(alu_op <= 4'd8 || alu_op == 4'd13) || inj_fault;
    end

    // Architectural result of an instruction, straight from RV32I semantics.
    task automatic ref_exec(input logic [31:0] ins, input logic [31:0] rs1, input logic [31:0] rs2,
                            output bit legal, output logic [31:0] val);
        logic [31:0] imm;
        logic [6:0]  opc, f7;
        logic [2:0]  f3;
        imm   = {{20{ins[31]}}, ins[31:20]};
        opc   = ins[6:0];
        f3    = ins[14:12];
        f7    = ins[31:25];
        legal = 1'b1;
        val   = '0;
        if (opc == 7'h13) begin
            case (f3)
                3'd0: val = rs1 + imm;
                3'd2: val = ($signed(rs1) < $signed(imm)) ? 32'd1 : 32'd0;
                3'd3: val = (rs1 < imm) ? 32'd1 : 32'd0;
                3'd4: val = rs1 ^ imm;
                3'd6: val = rs1 | imm;
                3'd7: val = rs1 & imm;
                3'd1: if (f7 == 7'h00) val = rs1 << ins[24:20]; else legal = 1'b0;
                default: begin
                    if (f7 == 7'h00)      val = rs1 >> ins[24:20];
                    else if (f7 == 7'h20) val = 32'($signed(rs1) >>> ins[24:20]);
                    else                  legal = 1'b0;
                end
            endcase
        end else if (opc == 7'h33) begin
            if (f7 == 7'h00) begin
                case (f3)
                    3'd0: val = rs1 + rs2;
                    3'd1: val = rs1 << rs2[4:0];
                    3'd2: val = ($signed(rs1) < $signed(rs2)) ? 32'd1 : 32'd0;
                    3'd3: val = (rs1 < rs2) ? 32'd1 : 32'd0;
                    3'd4: val = rs1 ^ rs2;
                    3'd5: val = rs1 >> rs2[4:0];
                    3'd6: val = rs1 | rs2;
                    default: val = rs1 & rs2;
                endcase
            end else if (f7 == 7'h20 && f3 == 3'd0) val = rs1 - rs2;
            else if (f7 == 7'h20 && f3 == 3'd5) val = 32'($signed(rs1) >>> rs2[4:0]);
            else legal = 1'b0;
        end else begin
            legal = 1'b0;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Call at a negedge; returns 1 ns after the accepting edge.
    task automatic send(input logic [31:0] ins, input logic [31:0] rs1, input logic [31:0] rs2, input bit inj);
        exp_t        e;
        bit          lg;
        logic [31:0] v;
        int          t;
        ref_exec(ins, rs1, rs2, lg, v);
        e.data  = lg ? v : 32'd0;
        e.rd    = ins[11:7];
        e.fault = lg ? inj : 1'b1;
        e.we    = lg && !inj && (ins[11:7] != 5'd0);
        e.lat   = lg ? 2 : 0;
        in_instr   = ins;
        in_rs1_val = rs1;
        in_rs2_val = rs2;
        in_valid   = 1'b1;
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected 1", t);
            in_valid = 1'b0;
            return;
        end
        e.acc = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        inj_fault  = inj;
        in_instr   = $urandom;
        in_rs1_val = $urandom;
        in_rs2_val = $urandom;
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || res_valid) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain_outstanding", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: latency, hold-under-backpressure and result fields at each handshake.
    bit          pv = 1'b0, pr = 1'b0;
    logic [31:0] p_data;
    logic [4:0]  p_rd;
    logic        p_fault, p_we;

    always @(negedge clk) begin
        if (!rst_n) begin
            pv <= 1'b0;
        end else begin
            if (res_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_result: res_valid=1 rd=%0d data=%h, expected no result", res_rd, res_data);
                end else begin
                    if (!pv) chk("valid_latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
                    if (pv && !pr) begin
                        chk("hold_data", res_data, p_data);
                        chk("hold_rd", 32'(res_rd), 32'(p_rd));
                        chk("hold_fault", 32'(res_fault), 32'(p_fault));
                        chk("hold_we", 32'(res_we), 32'(p_we));
                    end
                    if (res_ready) begin
                        chk("res_data", res_data, sb[0].data);
                        chk("res_rd", 32'(res_rd), 32'(sb[0].rd));
                        chk("res_fault", 32'(res_fault), 32'(sb[0].fault));
                        chk("res_we", 32'(res_we), 32'(sb[0].we));
                        void'(sb.pop_front());
                    end
                end
            end
            pv      <= res_valid;
            pr      <= res_ready;
            p_data  <= res_data;
            p_rd    <= res_rd;
            p_fault <= res_fault;
            p_we    <= res_we;
        end
    end

    initial begin
        res_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       res_ready = 1'b1;
                1:       res_ready = ($urandom_range(0, 3) != 0);
                default: res_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  s_op;
        logic [31:0] s_a, s_b, ins;
        longint      c0;
        int          t;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_instr   = '0;
        in_rs1_val = '0;
        in_rs2_val = '0;
        #12;
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_fault", 32'(res_fault), 32'd0);
        chk("rst_res_we", 32'(res_we), 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_res_rd", 32'(res_rd), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", 32'(in_ready), 32'd1);

        // ADDI x5,x1,-1
        send(32'hFFF08293, 32'd5, $urandom, 1'b0);
        chk("addi_alu_op", 32'(alu_op), 32'h0);
        chk("addi_alu_a", alu_a, 32'd5);
        chk("addi_alu_b", alu_b, 32'hFFFF_FFFF);
        drain();
        // SUB x3,x1,x2
        @(negedge clk);
        send(32'h402081B3, 32'd10, 32'd3, 1'b0);
        chk("sub_alu_op", 32'(alu_op), 32'h8);
        chk("sub_alu_b", alu_b, 32'd3);
        drain();
        // SRAI x4,x1,4
        @(negedge clk);
        send(32'h4040D213, 32'h8000_0000, $urandom, 1'b0);
        chk("srai_alu_op", 32'(alu_op), 32'hD);
        chk("srai_shamt", 32'(alu_b[4:0]), 32'd4);
        drain();

        // Illegal LW and MUL leave the ALU operands untouched
        s_op = alu_op; s_a = alu_a; s_b = alu_b;
        @(negedge clk);
        send(32'h0000A103, $urandom, $urandom, 1'b0);
        drain();
        @(negedge clk);
        send(32'h022081B3, $urandom, $urandom, 1'b0);
        drain();
        chk("illegal_alu_op_kept", 32'(alu_op), 32'(s_op));
        chk("illegal_alu_a_kept", alu_a, s_a);
        chk("illegal_alu_b_kept", alu_b, s_b);

        // ALU fault on a legal instruction
        @(negedge clk);
        send(32'h00308313, 32'd7, 32'd0, 1'b1);
        drain();

        // ADD x0,x1,x2 under backpressure, then a back-to-back instruction
        rr_mode = 2;
        @(negedge clk);
        send(32'h00208033, $urandom, $urandom, 1'b0);
        t = 0;
        while (!res_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("bp_valid_seen", 32'(res_valid), 32'd1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            chk("bp_valid_held", 32'(res_valid), 32'd1);
        end
        rr_mode = 0;
        t = 0;
        while (!res_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        chk("post_hs_in_ready", 32'(in_ready), 32'd1);
        chk("post_hs_valid_low", 32'(res_valid), 32'd0);
        c0 = cyc;
        send(32'h00A00593, $urandom, $urandom, 1'b0);
        chk("back_to_back_accept", 32'(cyc - c0), 32'd1);
        drain();

        // Reset during ISSUE abandons the instruction
        @(negedge clk);
        send(32'h00108093, 32'd41, $urandom, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("midrst_res_valid", 32'(res_valid), 32'd0);
        chk("midrst_res_data", res_data, 32'd0);
        chk("midrst_alu_op", 32'(alu_op), 32'd0);
        chk("midrst_alu_a", alu_a, 32'd0);
        chk("midrst_alu_b", alu_b, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        repeat (5) begin
            @(negedge clk);
            chk("midrst_no_stale", 32'(res_valid), 32'd0);
        end

        // Randomised traffic with random writeback backpressure
        rr_mode = 1;
        repeat (300) begin
            @(negedge clk);
            if ($urandom_range(0, 4) == 0) @(negedge clk);
            ins = $urandom;
            case ($urandom_range(0, 9))
                0, 1, 2, 3: ins[6:0] = 7'h13;
                4, 5, 6, 7: ins[6:0] = 7'h33;
                default:    ins[6:0] = 7'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0:       ins[31:25] = 7'h00;
                1:       ins[31:25] = 7'h20;
                2:       ins[31:25] = 7'h01;
                default: ins[31:25] = 7'($urandom);
            endcase
            send(ins, $urandom, $urandom, ($urandom_range(0, 9) == 0));
        end
        drain();
        rr_mode = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
